// File: rtl/pc_ctrl_unit.sv
// Fetch-stage program-counter control: sequential step, stall hold, redirect
// with one-cycle flush, opcode-triggered halt/resume and a saturating fetch counter.
module pc_ctrl_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  INSTR_BYTES  = 4,
    parameter logic [6:0]          HALT_OPCODE  = 7'b1111111,
    parameter int                  CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 pc_rst_n,
    input  logic                 stall,
    input  logic                 opcode_valid,
    input  logic [6:0]           opcode,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_target,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  pc_plus,
    output logic                 flush,
    output logic                 halted,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state_p1, state_nxt;
    logic [PC_WIDTH-1:0]  pc_p1, pc_nxt;
    logic                 flush_p1, flush_nxt;
    logic                 misalign_p1, misalign_nxt;
    logic [CNT_WIDTH-1:0] count_p1;
    logic                 count_en;

    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    endfunction

    assign pc_plus = pc_p1 + STEP;

    // Next-state decode: redirect > halt opcode > stall > sequential step
    always_comb begin
        state_nxt    = state_p1;
        pc_nxt       = pc_p1;
        flush_nxt    = 1'b0;
        misalign_nxt = misalign_p1;
        count_en     = 1'b0;
        case (state_p1)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_nxt    = align_pc(redirect_target);
                    flush_nxt = 1'b1;
                    count_en  = 1'b1;
                    if (|(redirect_target & ALIGN_MASK)) begin
                        misalign_nxt = 1'b1;
                    end
                end else if (opcode_valid && (opcode == HALT_OPCODE)) begin
                    state_nxt = ST_HALT;
                end else if (!stall) begin
                    pc_nxt   = pc_plus;
                    count_en = 1'b1;
                end
            end
            ST_HALT: begin
                // Resume steps past the halt instruction itself
                if (resume) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = pc_plus;
                    count_en  = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Stage p1: architectural PC state
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            state_p1    <= ST_RUN;
            pc_p1       <= RESET_VECTOR;
            flush_p1    <= 1'b0;
            misalign_p1 <= 1'b0;
            count_p1    <= '0;
        end else begin
            state_p1    <= state_nxt;
            pc_p1       <= pc_nxt;
            flush_p1    <= flush_nxt;
            misalign_p1 <= misalign_nxt;
            if (count_en) begin
                count_p1 <= sat_inc(count_p1);
            end
        end
    end

    assign pc           = pc_p1;
    assign flush        = flush_p1;
    assign halted       = (state_p1 == ST_HALT);
    assign misalign_err = misalign_p1;
    assign fetch_count  = count_p1;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Directed bench for pc_ctrl_unit: a default 32-bit instance plus an 8-bit
// instance with a 3-bit counter for wrap-around and saturation.
module tb_pc_ctrl_unit;

    logic        clk = 1'b0;
    int          n_pass = 0;
    int          n_checks = 0;

    // 32-bit instance
    logic        rst_n, stall, opcode_valid, redirect_valid, resume;
    logic [6:0]  opcode;
    logic [31:0] redirect_target, pc, pc_plus, fetch_count;
    logic        flush, halted, misalign_err;

    // 8-bit instance
    logic        s_rst_n, s_stall, s_opcode_valid, s_redirect_valid, s_resume;
    logic [6:0]  s_opcode;
    logic [7:0]  s_redirect_target, s_pc, s_pc_plus;
    logic [2:0]  s_fetch_count;
    logic        s_flush, s_halted, s_misalign_err;

    always #5 clk = ~clk;

    pc_ctrl_unit u_dut (
        .clk(clk), .pc_rst_n(rst_n), .stall(stall), .opcode_valid(opcode_valid),
        .opcode(opcode), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .resume(resume), .pc(pc), .pc_plus(pc_plus), .flush(flush), .halted(halted),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    pc_ctrl_unit #(.PC_WIDTH(8), .RESET_VECTOR(8'h10), .CNT_WIDTH(3)) u_dut8 (
        .clk(clk), .pc_rst_n(s_rst_n), .stall(s_stall), .opcode_valid(s_opcode_valid),
        .opcode(s_opcode), .redirect_valid(s_redirect_valid), .redirect_target(s_redirect_target),
        .resume(s_resume), .pc(s_pc), .pc_plus(s_pc_plus), .flush(s_flush), .halted(s_halted),
        .misalign_err(s_misalign_err), .fetch_count(s_fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                               input logic e_flush, input logic e_halt, input logic e_mis);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".cnt"}, fetch_count, e_cnt);
        check({tag, ".flush"}, flush, e_flush);
        check({tag, ".halted"}, halted, e_halt);
        check({tag, ".misalign"}, misalign_err, e_mis);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; opcode_valid = 1'b0; opcode = 7'h00;
        redirect_valid = 1'b0; redirect_target = '0; resume = 1'b0;
        s_rst_n = 1'b0; s_stall = 1'b0; s_opcode_valid = 1'b0; s_opcode = 7'h00;
        s_redirect_valid = 1'b0; s_redirect_target = '0; s_resume = 1'b0;

        step(); step();
        check_state("reset", 32'h0, 0, 1'b0, 1'b0, 1'b0);
        check("reset.pc_plus", pc_plus, 32'h4);
        check("reset8.pc", s_pc, 8'h10);
        check("reset8.cnt", s_fetch_count, 3'd0);

        // Sequential run
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("run.pc%0d", i), pc, 32'(4 * i));
            step();
        end
        check_state("run.end", 32'h14, 5, 1'b0, 1'b0, 1'b0);

        // Stall holds PC and counter
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("stall%0d", i), 32'h14, 5, 1'b0, 1'b0, 1'b0);
        end
        stall = 1'b0;
        step();
        check_state("stall.rel", 32'h18, 6, 1'b0, 1'b0, 1'b0);

        // Redirect beats stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        check_state("redir", 32'h100, 7, 1'b1, 1'b0, 1'b0);
        stall = 1'b0; redirect_valid = 1'b0;
        step();
        check_state("redir.next", 32'h104, 8, 1'b0, 1'b0, 1'b0);
        check("redir.pc_plus", pc_plus, 32'h108);

        // Back-to-back redirects keep flush high
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        check_state("b2b.0", 32'h200, 9, 1'b1, 1'b0, 1'b0);
        redirect_target = 32'h300;
        step();
        check_state("b2b.1", 32'h300, 10, 1'b1, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step();
        check_state("b2b.2", 32'h304, 11, 1'b0, 1'b0, 1'b0);

        // Misaligned target: cleared low bits, sticky error
        redirect_valid = 1'b1; redirect_target = 32'h103;
        step();
        check_state("mis.0", 32'h100, 12, 1'b1, 1'b0, 1'b1);
        redirect_target = 32'h200;
        step();
        check_state("mis.1", 32'h200, 13, 1'b1, 1'b0, 1'b1);
        redirect_valid = 1'b0;
        step();
        check_state("mis.2", 32'h204, 14, 1'b0, 1'b0, 1'b1);

        // Halt opcode without opcode_valid is ignored
        opcode = 7'h7F;
        step();
        check_state("noval", 32'h208, 15, 1'b0, 1'b0, 1'b1);

        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        check_state("pre.halt", 32'h40, 16, 1'b1, 1'b0, 1'b1);
        redirect_valid = 1'b0;

        // Halt taken even with stall asserted
        opcode_valid = 1'b1; stall = 1'b1;
        step();
        check_state("halt", 32'h40, 16, 1'b0, 1'b1, 1'b1);
        opcode_valid = 1'b0;
        redirect_target = 32'h500;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            redirect_valid = ~i[0];
            step();
            check_state($sformatf("halt.hold%0d", i), 32'h40, 16, 1'b0, 1'b1, 1'b1);
        end
        stall = 1'b0; redirect_valid = 1'b0;
        resume = 1'b1;
        step();
        check_state("resume", 32'h44, 17, 1'b0, 1'b0, 1'b1);
        resume = 1'b0;
        step();
        check_state("resume.next", 32'h48, 18, 1'b0, 1'b0, 1'b1);

        // Resume while running does not override stall
        stall = 1'b1; resume = 1'b1;
        step();
        check_state("resume.run", 32'h48, 18, 1'b0, 1'b0, 1'b1);
        stall = 1'b0; resume = 1'b0;

        // Asynchronous reset mid-halt
        opcode_valid = 1'b1;
        step();
        check_state("halt2", 32'h48, 18, 1'b0, 1'b1, 1'b1);
        opcode_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_state("async.rst", 32'h0, 0, 1'b0, 1'b0, 1'b0);
        step();
        check_state("async.hold", 32'h0, 0, 1'b0, 1'b0, 1'b0);

        // 8-bit instance: wrap-around and counter saturation
        s_rst_n = 1'b1;
        s_redirect_valid = 1'b1; s_redirect_target = 8'hF8;
        step();
        check("w8.pc0", s_pc, 8'hF8);
        check("w8.cnt0", s_fetch_count, 3'd1);
        s_redirect_valid = 1'b0;
        step();
        check("w8.pc1", s_pc, 8'hFC);
        check("w8.pc_plus", s_pc_plus, 8'h00);
        step();
        check("w8.wrap", s_pc, 8'h00);
        check("w8.cnt3", s_fetch_count, 3'd3);
        check("w8.mis", s_misalign_err, 1'b0);
        step(); step(); step(); step();
        check("w8.cnt7", s_fetch_count, 3'd7);
        check("w8.pc7", s_pc, 8'h10);
        step(); step();
        check("w8.sat", s_fetch_count, 3'd7);
        check("w8.pc9", s_pc, 8'h18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_unit.md
Name: pc_ctrl_unit

Overview:
- Parametrised program-counter control unit for the fetch stage of the pipelined RISC-V core.
- Generates the instruction fetch address and supports:
  - sequential increment,
  - pipeline stall hold,
  - branch/jump redirect with a one-cycle flush pulse,
  - halt on a configurable opcode, with resume.
- Keeps a saturating count of issued fetch addresses for debug/performance readout.

Parameters:
- PC_WIDTH, 32, width of the program counter and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must be a multiple of INSTR_BYTES.
- INSTR_BYTES, 4, sequential increment step. Power of two, 1..8.
- HALT_OPCODE, 7'b1111111, opcode value that halts the PC.
- CNT_WIDTH, 32, width of the fetch counter.

Ports:
- clk  in  1  core clock.
- pc_rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the PC this cycle (hazard unit).
- opcode_valid  in  1  the opcode input carries a decoded instruction this cycle.
- opcode  in  7  opcode of the instruction in decode.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  PC_WIDTH  branch/jump destination address.
- resume  in  1  leave HALT state.
- pc  out  PC_WIDTH  current instruction address (registered).
- pc_plus  out  PC_WIDTH  pc + INSTR_BYTES (combinational, wraps mod 2^PC_WIDTH).
- flush  out  1  one-cycle pulse: squash IF/ID contents.
- halted  out  1  high while in HALT state.
- misalign_err  out  1  sticky: a redirect target was not INSTR_BYTES-aligned.
- fetch_count  out  CNT_WIDTH  number of PC updates since reset (saturating).

Behaviour:
- Reset (pc_rst_n=0, asynchronous) forces:
  - pc=RESET_VECTOR, state=RUN,
  - flush=0, halted=0, misalign_err=0, fetch_count=0.
- Deassertion takes effect on the next rising clk edge.
- States are RUN and HALT. All updates occur on the rising clk edge.
- RUN, priority order, highest first:
  1. redirect_valid=1:
     - pc <= redirect_target with the low log2(INSTR_BYTES) bits cleared.
     - flush=1 on the following cycle.
     - If the cleared bits were nonzero, misalign_err <= 1 (sticky until reset).
     - Redirect overrides stall.
  2. opcode_valid=1 && opcode==HALT_OPCODE:
     - pc holds, state <= HALT, halted=1 from the next cycle.
     - Takes effect even when stall=1.
  3. stall=1: pc holds.
  4. Otherwise: pc <= pc_plus.
- HALT:
  - pc holds.
  - redirect_valid, stall and opcode are ignored; flush stays 0.
  - resume=1: state <= RUN and pc <= pc_plus, which skips the halt instruction. halted drops on the next cycle.
- resume in RUN: no effect.
- flush:
  - Registered. High for exactly one cycle after each accepted redirect.
  - Back-to-back redirects give a continuous high level.
- fetch_count:
  - Increments by 1 on every edge where pc changes value or is reloaded by redirect/resume.
  - Does not increment while holding (stall or HALT).
  - Saturates at 2^CNT_WIDTH-1; no wrap.
- Wrap-around: pc at 2^PC_WIDTH-INSTR_BYTES increments to 0 with no error.
- Reset asserted mid-stall or mid-HALT returns to RESET_VECTOR/RUN immediately; it does not wait for a clock edge.

Test Plan:
- Release reset with no stall, 5 cycles -> pc = 0x0, 0x4, 0x8, 0xC, 0x10; fetch_count=5; flush=0.
- pc=0x10, assert stall for 3 cycles, then release -> pc stays 0x10 for 3 cycles, then 0x14; fetch_count does not advance during the stall.
- pc=0x20, redirect_valid=1 with target 0x100 and stall=1 in the same cycle -> pc=0x100 next cycle; flush=1 for exactly one cycle; then pc=0x104.
- Redirect with target 0x103 -> pc=0x100; misalign_err=1 and stays 1 through later redirects until reset.
- pc=0x40, opcode_valid=1, opcode=7'h7F -> halted=1 and pc frozen at 0x40 over 10 cycles despite stall/redirect toggling. Then resume=1 -> pc=0x44, halted=0.
- PC_WIDTH=8, pc=0xFC, free run -> pc=0x00; no error. Separately, assert pc_rst_n low between clock edges while halted -> pc=RESET_VECTOR and halted=0 immediately.
